// File: rtl/checkpoint_buffer_pkg.sv
// Shared types and sizing for the branch-checkpoint buffer.
// The buffer size and id width are global macros, so other front-end
// blocks that carry checkpoint ids agree on the same width.
// Optional feature macro: CHECKPOINT_BUFFER_BYPASS_EN (see checkpoint_buffer.sv).

`ifndef CHECKPOINT_BUFFER_SIZE
`define CHECKPOINT_BUFFER_SIZE 64
`endif

`ifndef CHECKPOINT_ID_WIDTH
`define CHECKPOINT_ID_WIDTH 6
`endif

package checkpoint_buffer_pkg;

    localparam int CPBUF_DEPTH    = `CHECKPOINT_BUFFER_SIZE;
    localparam int CPBUF_ID_WIDTH = `CHECKPOINT_ID_WIDTH;

    // Predictor state captured when a branch/jump is dispatched, restored
    // by the BRU on a misprediction.
    typedef struct packed {
        logic [31:0] local_history;
        logic [15:0] global_history;
        logic [3:0]  ras_ptr;
    } checkpoint_t;

    // Commit-stage feedback. The buffer only looks at enable and flush.
    typedef struct packed {
        logic       enable;
        logic       flush;
        logic [6:0] commit_rob_id;
    } commit_feedback_pack_t;

endpackage

// File: rtl/checkpoint_buffer_if.sv
// Bundle of allocate / lookup / free signals around the checkpoint buffer.
// master: the surrounding pipeline (front end, BRU, commit).
// slave : the checkpoint buffer itself.

interface checkpoint_buffer_if #(
    parameter int ID_WIDTH = `CHECKPOINT_ID_WIDTH
) ();
    import checkpoint_buffer_pkg::*;

    // Allocation from the front end
    logic                  cpbuf_push_valid;
    checkpoint_t           cpbuf_push_data;
    logic                  cpbuf_push_ready;
    logic [ID_WIDTH-1:0]   cpbuf_push_id;

    // BRU lookup
    logic [ID_WIDTH-1:0]   exbru_cpbuf_id;
    checkpoint_t           cpbuf_exbru_data;

    // Commit-side free / flush
    logic                  commit_cpbuf_pop;
    commit_feedback_pack_t commit_feedback_pack;

    // Status
    logic                  cpbuf_empty;
    logic [ID_WIDTH:0]     cpbuf_count;

    modport master (
        output cpbuf_push_valid,
        output cpbuf_push_data,
        input  cpbuf_push_ready,
        input  cpbuf_push_id,
        output exbru_cpbuf_id,
        input  cpbuf_exbru_data,
        output commit_cpbuf_pop,
        output commit_feedback_pack,
        input  cpbuf_empty,
        input  cpbuf_count
    );

    modport slave (
        input  cpbuf_push_valid,
        input  cpbuf_push_data,
        output cpbuf_push_ready,
        output cpbuf_push_id,
        input  exbru_cpbuf_id,
        output cpbuf_exbru_data,
        input  commit_cpbuf_pop,
        input  commit_feedback_pack,
        output cpbuf_empty,
        output cpbuf_count
    );

endinterface

// File: rtl/checkpoint_buffer_ptr.sv
// Wrap-bit circular pointer: ID_WIDTH index bits plus one wrap bit, so that
// equal indices can be told apart as "empty" or "full" by the wrap bit.
// Clear has priority over increment.

module checkpoint_buffer_ptr #(
    parameter int ID_WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc_i,
    input  logic                clr_i,
    output logic [ID_WIDTH:0]   ptr_o,
    output logic [ID_WIDTH-1:0] idx_o
);

    logic [ID_WIDTH:0] ptr_q;
    logic [ID_WIDTH:0] ptr_d;

    // Next pointer: clear, else increment (wraps naturally modulo 2^(ID_WIDTH+1)).
    always_comb begin
        // NOTE: default assigned first so every path drives ptr_d and no latch is inferred.
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + (ID_WIDTH + 1)'(1);
        end
    end

    // Pointer register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
    assign idx_o = ptr_q[ID_WIDTH-1:0];

endmodule

// File: rtl/checkpoint_buffer.sv
// Circular buffer of branch-predictor checkpoints. Entries are allocated in
// program order by the front end, looked up by id from the BRU, freed in
// order at commit and dropped wholesale on a commit flush.
// Optional: CHECKPOINT_BUFFER_BYPASS_EN forwards a same-cycle push to the
// BRU lookup when the lookup id equals the tail index.

module checkpoint_buffer
    import checkpoint_buffer_pkg::*;
#(
    parameter int DEPTH    = `CHECKPOINT_BUFFER_SIZE,
    parameter int ID_WIDTH = `CHECKPOINT_ID_WIDTH
) (
    input  logic clk,
    input  logic rst,
    checkpoint_buffer_if.slave bus
);

    logic [ID_WIDTH:0]   head_ptr;
    logic [ID_WIDTH:0]   tail_ptr;
    logic [ID_WIDTH-1:0] head_idx;
    logic [ID_WIDTH-1:0] tail_idx;

    logic full;
    logic empty;
    logic flush;
    logic push_accept;   // handshake completes (valid && ready)
    logic push_commit;   // handshake completes and is not overridden by flush
    logic pop_commit;

    checkpoint_t mem_q [DEPTH];

    logic unused_feedback;
    assign unused_feedback = ^bus.commit_feedback_pack.commit_rob_id;

    // Status derived from registered pointers only, so a same-cycle pop
    // never makes room for a push.
    assign empty = (head_ptr == tail_ptr);
    assign full  = (head_idx == tail_idx) && (head_ptr[ID_WIDTH] != tail_ptr[ID_WIDTH]);
    assign flush = bus.commit_feedback_pack.enable && bus.commit_feedback_pack.flush;

    assign push_accept = bus.cpbuf_push_valid && !full;
    assign push_commit = push_accept && !flush;
    assign pop_commit  = bus.commit_cpbuf_pop && !empty && !flush;

    checkpoint_buffer_ptr #(.ID_WIDTH(ID_WIDTH)) u_head_ptr (
        .clk   (clk),
        .rst_n (rst),
        .inc_i (pop_commit),
        .clr_i (flush),
        .ptr_o (head_ptr),
        .idx_o (head_idx)
    );

    checkpoint_buffer_ptr #(.ID_WIDTH(ID_WIDTH)) u_tail_ptr (
        .clk   (clk),
        .rst_n (rst),
        .inc_i (push_commit),
        .clr_i (flush),
        .ptr_o (tail_ptr),
        .idx_o (tail_idx)
    );

    // Checkpoint storage: written at the tail on an accepted push; never
    // cleared by pop or flush, so freed slots keep their last contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this array is reset on purpose -- the BRU may read any slot, and
            // an unallocated slot must return zero rather than X after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_commit) begin
            mem_q[tail_idx] <= bus.cpbuf_push_data;
        end
    end

    // BRU lookup: zero-latency read, optionally bypassing a same-cycle push.
    always_comb begin
        bus.cpbuf_exbru_data = mem_q[bus.exbru_cpbuf_id];
`ifdef CHECKPOINT_BUFFER_BYPASS_EN
        // Forwarding keys off the handshake alone; a coincident flush does
        // not suppress it because this path is purely combinational.
        if (push_accept && (bus.exbru_cpbuf_id == tail_idx)) begin
            bus.cpbuf_exbru_data = bus.cpbuf_push_data;
        end
`endif
    end

    assign bus.cpbuf_push_ready = !full;
    assign bus.cpbuf_push_id    = tail_idx;
    assign bus.cpbuf_empty      = empty;
    assign bus.cpbuf_count      = tail_ptr - head_ptr;

endmodule

// File: tb/tb_checkpoint_buffer.sv
// Self-checking bench for checkpoint_buffer. A behavioural model (index
// counters plus a shadow array) tracks expected contents; expected push ids
// are queued when a push is driven and compared when the DUT reports them.

module tb_checkpoint_buffer;
    import checkpoint_buffer_pkg::*;

    localparam int DEPTH = 64;
    localparam int IDW   = 6;

    logic clk;
    logic rst;

    checkpoint_buffer_if #(.ID_WIDTH(IDW)) bus ();

    checkpoint_buffer #(.DEPTH(DEPTH), .ID_WIDTH(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model
    int          m_head  = 0;
    int          m_tail  = 0;
    int          m_count = 0;
    checkpoint_t m_mem [DEPTH];

    logic [IDW-1:0] exp_id_q [$];

    function automatic checkpoint_t make_cp(input logic [31:0] lh);
        checkpoint_t cp;
        cp.local_history  = lh;
        cp.global_history = lh[15:0] ^ 16'h5a5a;
        cp.ras_ptr        = lh[3:0];
        return cp;
    endfunction

    task automatic idle_inputs();
        bus.cpbuf_push_valid     = 1'b0;
        bus.cpbuf_push_data      = '0;
        bus.commit_cpbuf_pop     = 1'b0;
        bus.commit_feedback_pack = '0;
    endtask

    // One clock cycle: drive at edge+1, sample combinational outputs, clock,
    // update the model, return to edge+1 with inputs idle.
    task automatic drive_cycle(input logic push, input checkpoint_t data,
                               input logic pop, input logic flush,
                               output logic [IDW-1:0] seen_id,
                               output checkpoint_t seen_data);
        bus.cpbuf_push_valid            = push;
        bus.cpbuf_push_data             = data;
        bus.commit_cpbuf_pop            = pop;
        bus.commit_feedback_pack.enable = flush;
        bus.commit_feedback_pack.flush  = flush;
        #1;
        seen_id   = bus.cpbuf_push_id;
        seen_data = bus.cpbuf_exbru_data;
        @(posedge clk);
        #1;
        if (flush) begin
            m_head = 0; m_tail = 0; m_count = 0;
        end else begin
            logic was_full, was_empty;
            was_full  = (m_count == DEPTH);
            was_empty = (m_count == 0);
            if (push && !was_full) begin
                m_mem[m_tail] = data;
                m_tail  = (m_tail + 1) % DEPTH;
                m_count = m_count + 1;
            end
            if (pop && !was_empty) begin
                m_head  = (m_head + 1) % DEPTH;
                m_count = m_count - 1;
            end
        end
        idle_inputs();
    endtask

    task automatic push_one(input logic [31:0] lh);
        logic [IDW-1:0] sid;
        logic [IDW-1:0] eid;
        checkpoint_t    sd;
        exp_id_q.push_back(IDW'(m_tail));
        drive_cycle(1'b1, make_cp(lh), 1'b0, 1'b0, sid, sd);
        eid = exp_id_q.pop_front();
        n_total++;
        if (sid !== eid) $display("FAIL push_id: got %0d expected %0d", sid, eid);
        else n_pass++;
    endtask

    task automatic pop_one();
        logic [IDW-1:0] sid;
        checkpoint_t    sd;
        drive_cycle(1'b0, '0, 1'b1, 1'b0, sid, sd);
    endtask

    task automatic check_count(input string name);
        n_total++;
        if (bus.cpbuf_count !== (IDW+1)'(m_count))
            $display("FAIL %s count: got %0d expected %0d", name, bus.cpbuf_count, m_count);
        else n_pass++;
    endtask

    task automatic check_lookup(input string name, input int id, input logic [31:0] exp_lh);
        bus.exbru_cpbuf_id = IDW'(id);
        #1;
        n_total++;
        if (bus.cpbuf_exbru_data !== m_mem[id] || bus.cpbuf_exbru_data.local_history !== exp_lh)
            $display("FAIL %s lookup[%0d]: got %h expected %h", name, id,
                     bus.cpbuf_exbru_data, m_mem[id]);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        bus.exbru_cpbuf_id = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (bus.cpbuf_push_ready !== 1'b1) $display("FAIL reset ready: got %b expected 1", bus.cpbuf_push_ready);
        else n_pass++;
        n_total++;
        if (bus.cpbuf_empty !== 1'b1) $display("FAIL reset empty: got %b expected 1", bus.cpbuf_empty);
        else n_pass++;
        n_total++;
        if (bus.cpbuf_count !== 7'd0) $display("FAIL reset count: got %0d expected 0", bus.cpbuf_count);
        else n_pass++;
        n_total++;
        if (bus.cpbuf_push_id !== 6'd0) $display("FAIL reset push_id: got %0d expected 0", bus.cpbuf_push_id);
        else n_pass++;
        n_total++;
        if (bus.cpbuf_exbru_data !== '0) $display("FAIL reset lookup: got %h expected 0", bus.cpbuf_exbru_data);
        else n_pass++;
    endtask

    task automatic test_push_lookup();
        for (int i = 0; i < 36; i++) push_one(32'h1574a200 + 32'(i));
        check_count("push36");
        check_lookup("push36", 35, 32'h1574a223);
        check_lookup("push36", 0,  32'h1574a200);
        check_lookup("push36", 17, 32'h1574a211);
    endtask

    task automatic test_full();
        logic [IDW-1:0] sid;
        checkpoint_t    sd;
        for (int i = 36; i < DEPTH; i++) push_one(32'h1574a200 + 32'(i));
        n_total++;
        if (bus.cpbuf_push_ready !== 1'b0) $display("FAIL full ready: got %b expected 0", bus.cpbuf_push_ready);
        else n_pass++;
        check_count("full");
        // Push while full is ignored.
        drive_cycle(1'b1, make_cp(32'hdead0001), 1'b0, 1'b0, sid, sd);
        check_count("full_push");
        check_lookup("full_push", 0, 32'h1574a200);
        // Pop+push while full: only the pop happens.
        drive_cycle(1'b1, make_cp(32'hdead0002), 1'b1, 1'b0, sid, sd);
        check_count("full_pushpop");
        check_lookup("full_pushpop", 0, 32'h1574a200);
        n_total++;
        if (bus.cpbuf_push_ready !== 1'b1) $display("FAIL after_pop ready: got %b expected 1", bus.cpbuf_push_ready);
        else n_pass++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < DEPTH - 1; i++) pop_one();
        check_count("drain");
        n_total++;
        if (bus.cpbuf_empty !== 1'b1) $display("FAIL drain empty: got %b expected 1", bus.cpbuf_empty);
        else n_pass++;
        push_one(32'h0badf00d);          // index has wrapped back to 0
        check_count("wrap_push");
        check_lookup("wrap_push", 0, 32'h0badf00d);
        pop_one();
        pop_one();                       // pop while empty: ignored
        check_count("empty_pop");
        check_lookup("pop_keeps", 5, 32'h1574a205);
    endtask

    task automatic test_flush();
        logic [IDW-1:0] sid;
        checkpoint_t    sd;
        for (int i = 1; i <= 5; i++) push_one(32'hf1000000 + 32'(i));
        check_count("pre_flush");
        drive_cycle(1'b1, make_cp(32'h66666666), 1'b1, 1'b1, sid, sd);
        check_count("flush");
        n_total++;
        if (bus.cpbuf_empty !== 1'b1) $display("FAIL flush empty: got %b expected 1", bus.cpbuf_empty);
        else n_pass++;
        n_total++;
        if (bus.cpbuf_push_id !== 6'd0) $display("FAIL flush push_id: got %0d expected 0", bus.cpbuf_push_id);
        else n_pass++;
        check_lookup("flush_drop", 6, 32'h1574a206);
        check_lookup("flush_keep", 3, 32'hf1000003);
    endtask

    task automatic test_bypass();
        logic [IDW-1:0] sid;
        checkpoint_t    sd;
        logic [31:0]    exp_same;
        for (int i = 0; i < 7; i++) push_one(32'h000000b0 + 32'(i));
        bus.exbru_cpbuf_id = 6'd7;
`ifdef CHECKPOINT_BUFFER_BYPASS_EN
        exp_same = 32'h00001234;
`else
        exp_same = 32'h1574a207;
`endif
        drive_cycle(1'b1, make_cp(32'h00001234), 1'b0, 1'b0, sid, sd);
        n_total++;
        if (sd.local_history !== exp_same)
            $display("FAIL bypass same_cycle: got %h expected %h", sd.local_history, exp_same);
        else n_pass++;
        check_lookup("bypass_next", 7, 32'h00001234);
    endtask

    task automatic test_back_to_back();
        logic [IDW-1:0] sid;
        logic [IDW-1:0] eid;
        checkpoint_t    sd;
        for (int i = 0; i < 10; i++) begin
            exp_id_q.push_back(IDW'(m_tail));
            drive_cycle(1'b1, make_cp(32'hc0de0000 + 32'(i)), 1'b1, 1'b0, sid, sd);
            eid = exp_id_q.pop_front();
            n_total++;
            if (sid !== eid) $display("FAIL b2b push_id: got %0d expected %0d", sid, eid);
            else n_pass++;
        end
        check_count("b2b");
        check_lookup("b2b", 17, 32'hc0de0009);
    endtask

    task automatic test_async_reset();
        push_one(32'h77770000);
        push_one(32'h77770001);
        #2 rst = 1'b0;                   // between clock edges
        #1;
        n_total++;
        if (bus.cpbuf_count !== 7'd0 || bus.cpbuf_empty !== 1'b1)
            $display("FAIL async_reset state: got count=%0d empty=%b expected 0/1",
                     bus.cpbuf_count, bus.cpbuf_empty);
        else n_pass++;
        bus.exbru_cpbuf_id = 6'd18;
        #1;
        n_total++;
        if (bus.cpbuf_exbru_data !== '0)
            $display("FAIL async_reset storage: got %h expected 0", bus.cpbuf_exbru_data);
        else n_pass++;
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_push_lookup();
        test_full();
        test_wrap();
        test_flush();
        test_bypass();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
